dmac_mch_main_ctrl: RTL and testbench

//  Next-generation DMAC main controller: N-channel, parametrised successor to the 2-channel controller.
//  - Arbitrates peripheral requests (fixed-priority or round-robin).
//  - Requests the AHB bus and fetches a CFG_WORDS-long channel descriptor over the master interface, pipelined.
//  - Enables the winning channel, tracks pause/resume on bus-grant loss, and raises a per-channel interrupt on completion.
//  - Sits between the peripheral request lines, the AHB arbiter, the descriptor registers and the channel datapaths.

---
 rtl/dmac_pkg.sv | 23 ++
 rtl/dmac_arbiter.sv | 57 +++++
 rtl/dmac_mch_main_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dmac_mch_main_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// DMAC main controller shared types.
// AHB transfer codes, controller states and arbitration modes.
package dmac_pkg;

    typedef enum logic [1:0] {
        Idle    = 2'b00,
        Busy    = 2'b01,
        Non_Seq = 2'b10,
        Seq     = 2'b11
    } HTrans_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BUS_REQD = 3'd1,
        CFG      = 3'd2,
        START    = 3'd3,
        RUN      = 3'd4
    } ctrl_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/dmac_arbiter.sv
// DMAC request arbiter.
// Fixed priority (highest index) or round-robin from a stored pointer.
module dmac_arbiter
    import dmac_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ARB_MODE = ARB_FIXED
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      upd,
    input  logic [$clog2(NUM_CH)-1:0] cur_idx,
    output logic [NUM_CH-1:0]         gnt_oh,
    output logic [$clog2(NUM_CH)-1:0] gnt_idx
);

    localparam int IW = $clog2(NUM_CH);
    localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] jj;
    logic          found;

    // Pick the winner index from the latched request vector
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        jj      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == ARB_FIXED) begin
                if (req[k]) gnt_idx = IW'(k);
            end else begin
                jj = IW'((int'(rr_ptr) + k) % NUM_CH);
                if (!found && req[jj]) begin
                    gnt_idx = jj;
                    found   = 1'b1;
                end
            end
        end
    end

    assign gnt_oh = CH_ONE << gnt_idx;

    // Round-robin pointer moves past the channel that just completed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (upd) begin
            if (cur_idx == IW'(NUM_CH - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= cur_idx + IW'(1);
        end
    end

endmodule

// File: rtl/dmac_mch_main_ctrl.sv
// DMAC N-channel main controller.
// Arbitrates, fetches the descriptor over AHB, runs and completes a channel.
module dmac_mch_main_ctrl
    import dmac_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CFG_WORDS = 4,
    parameter int ARB_MODE  = ARB_FIXED
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            DmacReq,
    input  logic                         Bus_Grant,
    input  logic                         HReady,
    input  logic [NUM_CH-1:0]            Ch_Done,
    output logic                         Bus_Req,
    output logic [NUM_CH-1:0]            ReqAck,
    output logic [$clog2(NUM_CH)-1:0]    Active_Ch,
    output logic [$clog2(CFG_WORDS)-1:0] Cfg_Word_Idx,
    output logic [1:0]                   config_HTrans,
    output logic [CFG_WORDS-1:0]         Cfg_Reg_en,
    output logic [NUM_CH-1:0]            Channel_en,
    output logic                         Ch_Pause,
    output logic [NUM_CH-1:0]            Interrupt
);

    localparam int IW = $clog2(NUM_CH);
    localparam int CW = $clog2(CFG_WORDS);
    localparam logic [NUM_CH-1:0]    CH_ONE = NUM_CH'(1);
    localparam logic [CFG_WORDS-1:0] CW_ONE = CFG_WORDS'(1);

    ctrl_state_t state, nstate;

    logic [NUM_CH-1:0] req_q;
    logic [NUM_CH-1:0] ack_q;
    logic [IW-1:0]     act_q;
    logic [CW-1:0]     widx_q;
    logic [CW-1:0]     pidx_q;
    logic              pend_q;
    logic              issued_q;
    HTrans_t           ht_q;

    logic [NUM_CH-1:0] gnt_oh;
    logic [IW-1:0]     gnt_idx;
    logic [NUM_CH-1:0] ch_oh;
    logic              done_hit;
    logic              last_word;
    logic              run_done;

    assign ch_oh     = CH_ONE << act_q;
    assign done_hit  = Ch_Done[act_q];
    assign last_word = (widx_q == CW'(CFG_WORDS - 1));
    assign run_done  = (state == RUN) && done_hit;

    dmac_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_q),
        .upd     (run_done),
        .cur_idx (act_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next-state decode
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:
                if (|DmacReq) nstate = BUS_REQD;
            BUS_REQD:
                if (Bus_Grant && HReady) nstate = CFG;
            CFG:
                if (HReady && issued_q && ht_q == Idle) nstate = START;
            START:
                nstate = RUN;
            RUN:
                if (done_hit) nstate = (|DmacReq) ? BUS_REQD : IDLE;
            default:
                nstate = IDLE;
        endcase
    end

    // Request latch, winner capture and pipelined descriptor fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= '0;
            ack_q    <= '0;
            act_q    <= '0;
            widx_q   <= '0;
            pidx_q   <= '0;
            pend_q   <= 1'b0;
            issued_q <= 1'b0;
            ht_q     <= Idle;
        end else begin
            ack_q <= '0;
            if ((state == IDLE || run_done) && |DmacReq)
                req_q <= DmacReq;
            case (state)
                BUS_REQD: begin
                    if (Bus_Grant && HReady) begin
                        act_q    <= gnt_idx;
                        ack_q    <= gnt_oh;
                        ht_q     <= Non_Seq;
                        widx_q   <= '0;
                        pend_q   <= 1'b0;
                        issued_q <= 1'b0;
                    end
                end
                CFG: begin
                    if (HReady) begin
                        pend_q <= 1'b0;
                        if (!Bus_Grant) begin
                            ht_q <= Idle;
                        end else if (ht_q == Non_Seq) begin
                            pend_q <= 1'b1;
                            pidx_q <= widx_q;
                            if (last_word) begin
                                issued_q <= 1'b1;
                                ht_q     <= Idle;
                            end else begin
                                widx_q <= widx_q + CW'(1);
                            end
                        end else if (!issued_q) begin
                            ht_q <= Non_Seq;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode; write enable, pause and interrupt track live inputs
    always_comb begin
        Bus_Req    = (state != IDLE);
        Cfg_Reg_en = '0;
        Channel_en = '0;
        Ch_Pause   = 1'b0;
        Interrupt  = '0;
        case (state)
            CFG: begin
                if (HReady && pend_q) Cfg_Reg_en = CW_ONE << pidx_q;
            end
            RUN: begin
                Channel_en = ch_oh;
                Ch_Pause   = !Bus_Grant;
                if (done_hit) Interrupt = ch_oh;
            end
            default: ;
        endcase
    end

    assign ReqAck        = ack_q;
    assign Active_Ch     = act_q;
    assign Cfg_Word_Idx  = widx_q;
    assign config_HTrans = ht_q;

endmodule

// File: tb/tb_dmac_mch_main_ctrl.sv
// Bench for the DMAC main controller.
// Vector table for fetch/run sequences plus hand sequences for corners.
module tb_dmac_mch_main_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       gnt;
    logic       rdy;
    logic [3:0] done;

    logic       breq_f, pause_f;
    logic [3:0] ack_f, cen_f, chen_f, irq_f;
    logic [1:0] ach_f, widx_f, ht_f;

    logic       breq_r, pause_r;
    logic [3:0] ack_r, cen_r, chen_r, irq_r;
    logic [1:0] ach_r, widx_r, ht_r;

    logic [23:0] obs_f, obs_r;

    int n_cmp;
    int n_bad;
    int wcnt [4];

    typedef struct {
        logic        rb;
        logic [3:0]  rq;
        logic        g;
        logic        r;
        logic [3:0]  d;
        logic [23:0] exp;
    } vec_t;

    vec_t vq[$];

    dmac_mch_main_ctrl #(
        .NUM_CH(4), .CFG_WORDS(4), .ARB_MODE(0)
    ) dut_fx (
        .clk(clk), .rst(rst), .DmacReq(req), .Bus_Grant(gnt),
        .HReady(rdy), .Ch_Done(done), .Bus_Req(breq_f),
        .ReqAck(ack_f), .Active_Ch(ach_f), .Cfg_Word_Idx(widx_f),
        .config_HTrans(ht_f), .Cfg_Reg_en(cen_f),
        .Channel_en(chen_f), .Ch_Pause(pause_f), .Interrupt(irq_f)
    );

    dmac_mch_main_ctrl #(
        .NUM_CH(4), .CFG_WORDS(4), .ARB_MODE(1)
    ) dut_rr (
        .clk(clk), .rst(rst), .DmacReq(req), .Bus_Grant(gnt),
        .HReady(rdy), .Ch_Done(done), .Bus_Req(breq_r),
        .ReqAck(ack_r), .Active_Ch(ach_r), .Cfg_Word_Idx(widx_r),
        .config_HTrans(ht_r), .Cfg_Reg_en(cen_r),
        .Channel_en(chen_r), .Ch_Pause(pause_r), .Interrupt(irq_r)
    );

    assign obs_f = {breq_f, ack_f, ach_f, widx_f, ht_f,
                    cen_f, chen_f, pause_f, irq_f};
    assign obs_r = {breq_r, ack_r, ach_r, widx_r, ht_r,
                    cen_r, chen_r, pause_r, irq_r};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] rq, input logic g,
                        input logic r, input logic [3:0] d);
        @(negedge clk);
        req  = rq;
        gnt  = g;
        rdy  = r;
        done = d;
        #1;
        for (int k = 0; k < 4; k++) wcnt[k] += int'(cen_f[k]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        gnt  = 1'b0;
        rdy  = 1'b0;
        done = '0;
        #1;
        chk("reset_fx", 32'(obs_f), 32'h0);
        chk("reset_rr", 32'(obs_r), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add(
        input logic rb, input logic [3:0] rq, input logic g,
        input logic r, input logic [3:0] d,
        input logic eb, input logic [3:0] ea, input logic [1:0] ech,
        input logic [1:0] ewi, input logic [1:0] eht,
        input logic [3:0] ecen, input logic [3:0] echen,
        input logic ep, input logic [3:0] eirq);
        vec_t v;
        v.rb  = rb;
        v.rq  = rq;
        v.g   = g;
        v.r   = r;
        v.d   = d;
        v.exp = {eb, ea, ech, ewi, eht, ecen, echen, ep, eirq};
        vq.push_back(v);
    endtask

    initial begin
        int order [3];
        logic [3:0] oh;
        logic got;

        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        req   = '0;
        gnt   = 1'b0;
        rdy   = 1'b0;
        done  = '0;
        for (int k = 0; k < 4; k++) wcnt[k] = 0;

        // fixed priority fetch + run; done on other channel ignored;
        // done coincident with grant loss
        add(1, 4'b0110, 0, 1, 4'h0,  0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0);
        add(0, 4'b0110, 1, 1, 4'h0,  1, 4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0);
        add(0, 4'b0110, 1, 1, 4'h0,  1, 4'h4, 2, 0, 2, 4'h0, 4'h0, 0, 4'h0);
        add(0, 4'b0110, 1, 1, 4'h0,  1, 4'h0, 2, 1, 2, 4'h1, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h0,  1, 4'h0, 2, 2, 2, 4'h2, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h0,  1, 4'h0, 2, 3, 2, 4'h4, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h0,  1, 4'h0, 2, 3, 0, 4'h8, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h0,  1, 4'h0, 2, 3, 0, 4'h0, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h1,  1, 4'h0, 2, 3, 0, 4'h0, 4'h4, 0, 4'h0);
        add(0, 4'b0000, 0, 1, 4'h4,  1, 4'h0, 2, 3, 0, 4'h0, 4'h4, 1, 4'h4);
        add(0, 4'b0000, 1, 1, 4'h0,  0, 4'h0, 2, 3, 0, 4'h0, 4'h0, 0, 4'h0);
        // grant lost after word 1 issued, regrant re-issues word 1;
        // then grant low 5 cycles in RUN
        add(1, 4'b0010, 0, 1, 4'h0,  0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0);
        add(0, 4'b0010, 1, 1, 4'h0,  1, 4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0);
        add(0, 4'b0010, 1, 1, 4'h0,  1, 4'h2, 1, 0, 2, 4'h0, 4'h0, 0, 4'h0);
        add(0, 4'b0010, 0, 1, 4'h0,  1, 4'h0, 1, 1, 2, 4'h1, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 0, 1, 4'h0,  1, 4'h0, 1, 1, 0, 4'h0, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h0,  1, 4'h0, 1, 1, 0, 4'h0, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h0,  1, 4'h0, 1, 1, 2, 4'h0, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h0,  1, 4'h0, 1, 2, 2, 4'h2, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h0,  1, 4'h0, 1, 3, 2, 4'h4, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h0,  1, 4'h0, 1, 3, 0, 4'h8, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h0,  1, 4'h0, 1, 3, 0, 4'h0, 4'h0, 0, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h0,  1, 4'h0, 1, 3, 0, 4'h0, 4'h2, 0, 4'h0);
        for (int i = 0; i < 5; i++)
            add(0, 4'b0000, 0, 1, 4'h0,
                1, 4'h0, 1, 3, 0, 4'h0, 4'h2, 1, 4'h0);
        add(0, 4'b0000, 1, 1, 4'h2,  1, 4'h0, 1, 3, 0, 4'h0, 4'h2, 0, 4'h2);
        add(0, 4'b0000, 1, 1, 4'h0,  0, 4'h0, 1, 3, 0, 4'h0, 4'h0, 0, 4'h0);

        foreach (vq[i]) begin
            if (vq[i].rb) do_reset();
            step(vq[i].rq, vq[i].g, vq[i].r, vq[i].d);
            chk($sformatf("vec%0d", i), 32'(obs_f), 32'(vq[i].exp));
        end

        // HReady low 3 cycles while word 2 is in address phase
        do_reset();
        for (int k = 0; k < 4; k++) wcnt[k] = 0;
        step(4'b1000, 1, 1, 4'h0);
        step(4'b1000, 1, 1, 4'h0);
        step(4'b1000, 1, 1, 4'h0);
        step(4'b1000, 1, 1, 4'h0);
        chk("stall_pre_widx", 32'(widx_f), 32'd1);
        for (int c = 0; c < 3; c++) begin
            step(4'b1000, 1, 0, 4'h0);
            chk($sformatf("stall%0d", c),
                32'({widx_f, ht_f, cen_f}), 32'({2'd2, 2'd2, 4'h0}));
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            step(4'b1000, 1, 1, 4'h0);
            if (chen_f != 4'h0) got = 1'b1;
        end
        chk("stall_chen", 32'(chen_f), 32'h8);
        for (int k = 0; k < 4; k++)
            chk($sformatf("stall_wr%0d", k), 32'(wcnt[k]), 32'd1);

        // round-robin with DmacReq=1001 held: ch0, ch3, ch0
        do_reset();
        order = '{0, 3, 0};
        for (int s = 0; s < 3; s++) begin
            oh  = 4'b0001 << order[s];
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                step(4'b1001, 1, 1, 4'h0);
                if (ack_r != 4'h0) got = 1'b1;
            end
            if (!got) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rr_ack_wait%0d: got none expected %h", s, oh);
            end
            chk($sformatf("rr_ack%0d", s), 32'(ack_r), 32'(oh));
            chk($sformatf("rr_ach%0d", s), 32'(ach_r), 32'(order[s]));
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                step(4'b1001, 1, 1, 4'h0);
                if (chen_r != 4'h0) got = 1'b1;
            end
            chk($sformatf("rr_chen%0d", s), 32'(chen_r), 32'(oh));
            step(4'b1001, 1, 1, oh);
            chk($sformatf("rr_irq%0d", s), 32'(irq_r), 32'(oh));
            step(4'b1001, 1, 1, 4'h0);
            chk($sformatf("rr_breq%0d", s), 32'(breq_r), 32'd1);
        end

        // reset during word 2, pending request restarts from word 0
        do_reset();
        step(4'b0001, 1, 1, 4'h0);
        step(4'b0001, 1, 1, 4'h0);
        step(4'b0001, 1, 1, 4'h0);
        step(4'b0001, 1, 1, 4'h0);
        step(4'b0001, 1, 1, 4'h0);
        chk("mid_widx", 32'(widx_f), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out", 32'(obs_f), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_idle", 32'(obs_f), 32'h0);
        step(4'b0001, 1, 1, 4'h0);
        chk("post_rst_breq", 32'(breq_f), 32'd1);
        step(4'b0001, 1, 1, 4'h0);
        chk("post_rst_w0", 32'({ack_f, ach_f, widx_f, ht_f}),
            32'({4'h1, 2'd0, 2'd0, 2'd2}));
        step(4'b0001, 1, 1, 4'h0);
        chk("post_rst_en0", 32'(cen_f), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
